contador_param: RTL and testbench



---
 rtl/contador_pkg.sv | 18 +
 rtl/contador_param_if.sv | 26 ++
 rtl/contador_param_prescaler_tick.sv | 51 +++++
 rtl/contador_param.sv | 114 +++++++++++
 tb/tb_contador_param.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/contador_pkg.sv
// Shared constants and helpers for the parametrised event/timing counter.
package contador_pkg;

  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_SAT  = 1'b1;
  localparam bit DIR_UP    = 1'b1;
  localparam bit DIR_DOWN  = 1'b0;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((32'sd1 << result) < value) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/contador_param_if.sv
// Control/status bundle between the counter and its user.
interface contador_param_if #(
  parameter int WIDTH = 4
) ();

  logic             enable;
  logic             up_down;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] cont;
  logic             terminal;
  logic             wrap_pulse;
  logic             step;

  modport master (
    output enable, up_down, clear, load, load_value,
    input  cont, terminal, wrap_pulse, step
  );

  modport slave (
    input  enable, up_down, clear, load, load_value,
    output cont, terminal, wrap_pulse, step
  );

endinterface

// File: rtl/contador_param_prescaler_tick.sv
// Enable prescaler: emits a tick on every PRESCALE-th enabled cycle.
module prescaler_tick
  import contador_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

  if (PRESCALE < 1) begin : g_bad_prescale
    $fatal(1, "prescaler_tick: PRESCALE must be >= 1");
  end

  logic [PW-1:0] p_q;
  logic [PW-1:0] p_d;

  // Phase is frozen while enable is low so a paused count resumes mid-period.
  always_comb begin
    p_d = p_q;
    if (clear) begin
      p_d = '0;
    end else if (enable) begin
      if (p_q == P_LAST) begin
        p_d = '0;
      end else begin
        p_d = p_q + PW'(1'b1);
      end
    end else begin
      p_d = p_q;
    end
  end

  // Phase register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign tick = enable && (p_q == P_LAST);

endmodule

// File: rtl/contador_param.sv
// Parametrised up/down event counter with clear, clamped load, prescaled
// enable, wrap or saturate at the range ends, terminal flag and wrap pulse.
module contador_param
  import contador_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 16,
  parameter bit SATURATE = 1'b0,
  parameter int PRESCALE = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  contador_param_if.slave   bus
);

  if ((WIDTH < 1) || (WIDTH > 30)) begin : g_bad_width
    $fatal(1, "contador_param: WIDTH out of range");
  end
  if ((MODULO < 2) || (MODULO > (32'sd1 << WIDTH))) begin : g_bad_modulo
    $fatal(1, "contador_param: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $fatal(1, "contador_param: PRESCALE must be >= 1");
  end

  // One spare bit keeps MODULO-1 and +/-1 exact even when MODULO == 2**WIDTH.
  localparam logic [WIDTH:0]   TOP_EXT = (WIDTH + 1)'(MODULO - 1);
  localparam logic [WIDTH:0]   ONE_EXT = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] TOP_VAL = TOP_EXT[WIDTH-1:0];

  logic [WIDTH-1:0] cont_q;
  logic [WIDTH-1:0] cont_d;
  logic             wrap_q;
  logic             wrap_d;

  logic             tick_s;
  logic             step_s;
  logic             at_top_s;
  logic             at_bot_s;
  logic [WIDTH:0]   cont_ext_s;
  logic [WIDTH:0]   nxt_ext_s;

  prescaler_tick #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (bus.enable),
    .clear   (bus.clear | bus.load),
    .tick    (tick_s)
  );

  assign step_s     = bus.enable && tick_s;
  assign cont_ext_s = {1'b0, cont_q};
  assign at_top_s   = (cont_ext_s == TOP_EXT);
  assign at_bot_s   = (cont_q == '0);

  // Next count: clear > load > step > hold; the final compare clamps loads
  // and guarantees the count never leaves 0..MODULO-1.
  always_comb begin
    nxt_ext_s = cont_ext_s;
    wrap_d    = 1'b0;
    if (bus.clear) begin
      nxt_ext_s = '0;
    end else if (bus.load) begin
      nxt_ext_s = {1'b0, bus.load_value};
    end else if (step_s) begin
      if (bus.up_down == DIR_UP) begin
        if (!at_top_s) begin
          nxt_ext_s = cont_ext_s + ONE_EXT;
        end else if (SATURATE == MODE_SAT) begin
          nxt_ext_s = cont_ext_s;
        end else begin
          nxt_ext_s = '0;
          wrap_d    = 1'b1;
        end
      end else begin
        if (!at_bot_s) begin
          nxt_ext_s = cont_ext_s - ONE_EXT;
        end else if (SATURATE == MODE_SAT) begin
          nxt_ext_s = cont_ext_s;
        end else begin
          nxt_ext_s = TOP_EXT;
          wrap_d    = 1'b1;
        end
      end
    end else begin
      nxt_ext_s = cont_ext_s;
    end

    if (nxt_ext_s > TOP_EXT) begin
      cont_d = TOP_VAL;
    end else begin
      cont_d = nxt_ext_s[WIDTH-1:0];
    end
  end

  // Count and wrap-pulse registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cont_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      cont_q <= cont_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.cont       = cont_q;
  assign bus.wrap_pulse = wrap_q;
  assign bus.step       = step_s;
  assign bus.terminal   = (bus.up_down == DIR_UP) ? at_top_s : at_bot_s;

endmodule

// File: tb/tb_contador_param.sv
// Directed self-checking bench for contador_param across several parameter sets.
module tb_contador_param;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // if0: W4 M16 wrap P1 | if1: W4 M10 wrap P1 | if2: W4 M10 sat P1
  // if3: W4 M10 wrap P3 | if4: W8 M256 wrap P1
  contador_param_if #(.WIDTH(4)) if0 ();
  contador_param_if #(.WIDTH(4)) if1 ();
  contador_param_if #(.WIDTH(4)) if2 ();
  contador_param_if #(.WIDTH(4)) if3 ();
  contador_param_if #(.WIDTH(8)) if4 ();

  contador_param #(.WIDTH(4), .MODULO(16), .SATURATE(1'b0), .PRESCALE(1))
    dut0 (.clock(clk), .reset_n(rst_n), .bus(if0));
  contador_param #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0), .PRESCALE(1))
    dut1 (.clock(clk), .reset_n(rst_n), .bus(if1));
  contador_param #(.WIDTH(4), .MODULO(10), .SATURATE(1'b1), .PRESCALE(1))
    dut2 (.clock(clk), .reset_n(rst_n), .bus(if2));
  contador_param #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0), .PRESCALE(3))
    dut3 (.clock(clk), .reset_n(rst_n), .bus(if3));
  contador_param #(.WIDTH(8), .MODULO(256), .SATURATE(1'b0), .PRESCALE(1))
    dut4 (.clock(clk), .reset_n(rst_n), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (if0.cont !== 4'd0) begin errors++; $display("FAIL reset_cont0 got %0d want 0", if0.cont); end
    checks++; if (if0.wrap_pulse !== 1'b0) begin errors++; $display("FAIL reset_wrap0 got %b want 0", if0.wrap_pulse); end
    checks++; if (if3.cont !== 4'd0) begin errors++; $display("FAIL reset_cont3 got %0d want 0", if3.cont); end
    checks++; if (if4.cont !== 8'd0) begin errors++; $display("FAIL reset_cont4 got %0d want 0", if4.cont); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_up_wrap();
    logic [3:0] exp_c;
    logic       exp_w;
    if0.up_down = 1'b1;
    if0.enable  = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      cyc();
      exp_c = 4'(i % 16);
      exp_w = (i == 16);
      checks++; if (if0.cont !== exp_c) begin errors++; $display("FAIL up_wrap_cont step %0d got %0d want %0d", i, if0.cont, exp_c); end
      checks++; if (if0.wrap_pulse !== exp_w) begin errors++; $display("FAIL up_wrap_pulse step %0d got %b want %b", i, if0.wrap_pulse, exp_w); end
    end
  endtask

  task automatic test_async_reset();
    cyc();
    cyc();
    checks++; if (if0.cont !== 4'd3) begin errors++; $display("FAIL pre_reset_cont got %0d want 3", if0.cont); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (if0.cont !== 4'd0) begin errors++; $display("FAIL async_reset_cont got %0d want 0", if0.cont); end
    if0.enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    checks++; if (if0.cont !== 4'd0) begin errors++; $display("FAIL post_reset_hold got %0d want 0", if0.cont); end
  endtask

  task automatic test_down_wrap();
    if1.up_down = 1'b0;
    #1;
    checks++; if (if1.terminal !== 1'b1) begin errors++; $display("FAIL down_terminal_at0 got %b want 1", if1.terminal); end
    if1.enable = 1'b1;
    cyc();
    if1.enable = 1'b0;
    checks++; if (if1.cont !== 4'd9) begin errors++; $display("FAIL down_wrap_cont got %0d want 9", if1.cont); end
    checks++; if (if1.wrap_pulse !== 1'b1) begin errors++; $display("FAIL down_wrap_pulse got %b want 1", if1.wrap_pulse); end
    cyc();
    checks++; if (if1.wrap_pulse !== 1'b0) begin errors++; $display("FAIL down_wrap_pulse_end got %b want 0", if1.wrap_pulse); end
  endtask

  task automatic test_saturate();
    if2.load       = 1'b1;
    if2.load_value = 4'd1;
    cyc();
    if2.load = 1'b0;
    checks++; if (if2.cont !== 4'd1) begin errors++; $display("FAIL sat_load1 got %0d want 1", if2.cont); end
    if2.up_down = 1'b0;
    if2.enable  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (if2.cont !== 4'd0) begin errors++; $display("FAIL sat_down_cont step %0d got %0d want 0", i, if2.cont); end
      checks++; if (if2.wrap_pulse !== 1'b0) begin errors++; $display("FAIL sat_down_pulse step %0d got %b want 0", i, if2.wrap_pulse); end
      checks++; if (if2.terminal !== 1'b1) begin errors++; $display("FAIL sat_down_terminal step %0d got %b want 1", i, if2.terminal); end
    end
    if2.enable     = 1'b0;
    if2.load       = 1'b1;
    if2.load_value = 4'd13;
    cyc();
    if2.load = 1'b0;
    checks++; if (if2.cont !== 4'd9) begin errors++; $display("FAIL sat_load_clamp got %0d want 9", if2.cont); end
    if2.up_down = 1'b1;
    if2.enable  = 1'b1;
    cyc();
    if2.enable = 1'b0;
    checks++; if (if2.cont !== 4'd9) begin errors++; $display("FAIL sat_up_hold got %0d want 9", if2.cont); end
    checks++; if (if2.wrap_pulse !== 1'b0) begin errors++; $display("FAIL sat_up_pulse got %b want 0", if2.wrap_pulse); end
  endtask

  task automatic test_priority();
    if1.clear      = 1'b1;
    if1.load       = 1'b1;
    if1.load_value = 4'd5;
    if1.enable     = 1'b1;
    if1.up_down    = 1'b1;
    cyc();
    if1.clear  = 1'b0;
    if1.enable = 1'b0;
    checks++; if (if1.cont !== 4'd0) begin errors++; $display("FAIL prio_clear_over_load got %0d want 0", if1.cont); end
    if1.load_value = 4'd13;
    cyc();
    checks++; if (if1.cont !== 4'd9) begin errors++; $display("FAIL load_clamp got %0d want 9", if1.cont); end
    if1.load_value = 4'd7;
    cyc();
    if1.load = 1'b0;
    checks++; if (if1.cont !== 4'd7) begin errors++; $display("FAIL load_plain got %0d want 7", if1.cont); end
  endtask

  task automatic test_prescaler();
    logic       en_v   [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       step_v [11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] cont_v [11] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd3};
    if3.up_down = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if3.enable = en_v[i];
      #1;
      checks++; if (if3.step !== step_v[i]) begin errors++; $display("FAIL presc_step edge %0d got %b want %b", i, if3.step, step_v[i]); end
      cyc();
      checks++; if (if3.cont !== cont_v[i]) begin errors++; $display("FAIL presc_cont edge %0d got %0d want %0d", i, if3.cont, cont_v[i]); end
    end
    cyc();
    if3.load       = 1'b1;
    if3.load_value = 4'd5;
    cyc();
    if3.load = 1'b0;
    checks++; if (if3.cont !== 4'd5) begin errors++; $display("FAIL presc_load got %0d want 5", if3.cont); end
    cyc();
    checks++; if (if3.cont !== 4'd5) begin errors++; $display("FAIL presc_restart1 got %0d want 5", if3.cont); end
    cyc();
    checks++; if (if3.cont !== 4'd5) begin errors++; $display("FAIL presc_restart2 got %0d want 5", if3.cont); end
    cyc();
    if3.enable = 1'b0;
    checks++; if (if3.cont !== 4'd6) begin errors++; $display("FAIL presc_restart3 got %0d want 6", if3.cont); end
  endtask

  task automatic test_dir_switch();
    if0.load       = 1'b1;
    if0.load_value = 4'd15;
    cyc();
    if0.load = 1'b0;
    checks++; if (if0.cont !== 4'd15) begin errors++; $display("FAIL dir_load15 got %0d want 15", if0.cont); end
    if0.up_down = 1'b1;
    #1;
    checks++; if (if0.terminal !== 1'b1) begin errors++; $display("FAIL dir_terminal_up got %b want 1", if0.terminal); end
    if0.up_down = 1'b0;
    #1;
    checks++; if (if0.terminal !== 1'b0) begin errors++; $display("FAIL dir_terminal_down got %b want 0", if0.terminal); end
    if0.enable = 1'b1;
    cyc();
    if0.enable = 1'b0;
    checks++; if (if0.cont !== 4'd14) begin errors++; $display("FAIL dir_step_down got %0d want 14", if0.cont); end
    checks++; if (if0.wrap_pulse !== 1'b0) begin errors++; $display("FAIL dir_no_pulse got %b want 0", if0.wrap_pulse); end
  endtask

  task automatic test_full_range();
    int wraps;
    bit any_x;
    wraps       = 0;
    any_x       = 1'b0;
    if4.up_down = 1'b1;
    if4.enable  = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      cyc();
      if (if4.wrap_pulse === 1'b1) wraps++;
      if ($isunknown(if4.cont) || $isunknown(if4.wrap_pulse)) any_x = 1'b1;
      if (i == 255) begin
        checks++; if (if4.cont !== 8'd255) begin errors++; $display("FAIL full_cont255 got %0d want 255", if4.cont); end
        checks++; if (if4.terminal !== 1'b1) begin errors++; $display("FAIL full_terminal255 got %b want 1", if4.terminal); end
      end
    end
    if4.enable = 1'b0;
    checks++; if (if4.cont !== 8'd0) begin errors++; $display("FAIL full_return0 got %0d want 0", if4.cont); end
    checks++; if (if4.wrap_pulse !== 1'b1) begin errors++; $display("FAIL full_last_pulse got %b want 1", if4.wrap_pulse); end
    checks++; if (wraps != 1) begin errors++; $display("FAIL full_pulse_count got %0d want 1", wraps); end
    checks++; if (any_x) begin errors++; $display("FAIL full_unknown got %b want 0", any_x); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    if0.enable = 1'b0; if0.up_down = 1'b1; if0.clear = 1'b0; if0.load = 1'b0; if0.load_value = 4'd0;
    if1.enable = 1'b0; if1.up_down = 1'b1; if1.clear = 1'b0; if1.load = 1'b0; if1.load_value = 4'd0;
    if2.enable = 1'b0; if2.up_down = 1'b1; if2.clear = 1'b0; if2.load = 1'b0; if2.load_value = 4'd0;
    if3.enable = 1'b0; if3.up_down = 1'b1; if3.clear = 1'b0; if3.load = 1'b0; if3.load_value = 4'd0;
    if4.enable = 1'b0; if4.up_down = 1'b1; if4.clear = 1'b0; if4.load = 1'b0; if4.load_value = 8'd0;

    test_reset();
    test_up_wrap();
    test_async_reset();
    test_down_wrap();
    test_saturate();
    test_priority();
    test_prescaler();
    test_dir_switch();
    test_full_range();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
